// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver, LSB first, with 3-sample majority voting,
// start-glitch rejection, a valid/ack hold register and framing/overrun pulses.
module uart_rx_byte #(
  parameter int CLK_FREQ   = 7_372_800,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  // A sample is taken on the tick that moves scnt onto OS/2-1, OS/2, OS/2+1,
  // so those three samples straddle the bit centre.
  localparam logic [SW-1:0] S_A    = SW'(OVERSAMPLE / 2 - 2);
  localparam logic [SW-1:0] S_B    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_DEC  = SW'(OVERSAMPLE / 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic            rx_meta, rx_s;
  logic [1:0]      fill;
  logic            armed;
  logic [TW-1:0]   tcnt;
  logic [SW-1:0]   scnt;
  logic            maj_a, maj_b, maj;
  logic [7:0]      shreg;
  logic [2:0]      bcnt;
  logic            tick, decide, wrap;
  logic            enter, shift_en, stop_ok, stop_bad;

  assign tick    = (tcnt == T_LAST);
  assign decide  = tick && (scnt == S_DEC);
  assign wrap    = tick && (scnt == S_LAST);
  assign maj     = (maj_a & maj_b) | (maj_a & rx_s) | (maj_b & rx_s);
  assign rx_busy = (state != IDLE);

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // Start-arm flag: set only once the synchroniser holds real line data at 1,
  // cleared by a framing error so a held break cannot retrigger a start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      fill <= {fill[0], 1'b1};
      if (stop_bad)
        armed <= 1'b0;
      else if (fill[1] && rx_s)
        armed <= 1'b1;
    end
  end

  // Tick divider and oversample counter, both realigned on start detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
      scnt <= '0;
    end else if (enter) begin
      tcnt <= '0;
      scnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
      scnt <= (scnt == S_LAST) ? '0 : scnt + SW'(1);
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // Sample capture, data shift register and data-bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      maj_a <= 1'b1;
      maj_b <= 1'b1;
      shreg <= '0;
      bcnt  <= '0;
    end else begin
      if (tick && scnt == S_A) maj_a <= rx_s;
      if (tick && scnt == S_B) maj_b <= rx_s;
      if (shift_en) shreg <= {maj, shreg[7:1]};
      if (enter)
        bcnt <= '0;
      else if (state == DATA && wrap)
        bcnt <= bcnt + 3'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state and control strobes.
  always_comb begin
    state_next = state;
    enter      = 1'b0;
    shift_en   = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !rx_s) begin
          state_next = START;
          enter      = 1'b1;
        end
      end
      START: begin
        if (decide && maj)
          state_next = IDLE;
        else if (wrap)
          state_next = DATA;
      end
      DATA: begin
        if (decide) shift_en = 1'b1;
        if (wrap && bcnt == 3'd7) state_next = STOP;
      end
      STOP: begin
        if (decide) begin
          state_next = IDLE;
          stop_ok    = maj;
          stop_bad   = !maj;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Hold register, handshake and one-clock error pulses. An ack coinciding
  // with a capture frees the register for the new byte, so no overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= stop_bad;
      overrun_err <= stop_ok && rx_valid && !rx_ack;
      if (stop_ok && (!rx_valid || rx_ack)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: the sender pushes the expected event of
// each frame, an independent monitor pops and compares on DUT output events.
module tb_uart_rx_byte;

  localparam int BIT = 64;
  localparam int EV_BYTE = 0;
  localparam int EV_FE   = 1;
  localparam int EV_OV   = 2;

  logic       clk, reset, rx_in, rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun_err;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         t0;
    bit         lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  bit   auto_ack = 1'b1;
  bit   man_ack = 1'b0;
  bit   pending = 1'b0;

  uart_rx_byte #(
    .CLK_FREQ  (7_372_800),
    .BAUD_RATE (115_200),
    .OVERSAMPLE(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #(700_000);
    $display("FAIL watchdog: run still active at cycle %0d, required to finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a good stop bit yields the byte unless the previous one
  // is still unacknowledged (overrun); a low stop bit yields a framing error.
  task automatic send_frame(input logic [7:0] d, input int bl, input bit stop_hi, input bit lat);
    exp_t e;
    e.data = d;
    e.t0   = cyc;
    e.lat  = lat;
    if (!stop_hi)     e.kind = EV_FE;
    else if (pending) e.kind = EV_OV;
    else begin
      e.kind  = EV_BYTE;
      pending = !auto_ack;
    end
    exp_q.push_back(e);
    rx_in = 1'b0;
    hold(bl);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      hold(bl);
    end
    rx_in = stop_hi;
    hold(bl);
  endtask

  task automatic handle(input int kind, input logic [7:0] d);
    exp_t e;
    int lat;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_event: got kind %0d data 0x%0h, expected no event", kind, d);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (e.kind == EV_BYTE && kind == EV_BYTE) chk("rx_data", d, e.data);
      if (e.lat) begin
        lat = cyc - e.t0;
        checks++;
        if (lat >= 606 && lat <= 618) passes++;
        else $display("FAIL latency: got %0d clk, expected 606..618", lat);
      end
    end
  endtask

  // Monitor: reacts to valid rising and to error pulses.
  initial begin
    bit prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        if (rx_valid && !prev_v) handle(EV_BYTE, rx_data);
        if (frame_err)           handle(EV_FE, 8'h00);
        if (overrun_err)         handle(EV_OV, 8'h00);
        prev_v = rx_valid;
      end
    end
  end

  // Consumer: pulses rx_ack one clock after rx_valid when enabled.
  initial begin
    rx_ack = 1'b0;
    forever begin
      @(negedge clk);
      rx_ack = rx_valid && !rx_ack && (auto_ack || man_ack);
    end
  end

  initial begin
    logic [7:0] c3;
    logic [7:0] rd;
    reset = 1'b1;
    rx_in = 1'b1;
    hold(5);
    reset = 1'b0;
    hold(20);
    chk("reset_valid", rx_valid, 0);
    chk("reset_data", rx_data, 0);
    chk("reset_busy", rx_busy, 0);
    chk("reset_ferr", frame_err, 0);
    chk("reset_ovr", overrun_err, 0);

    // Basic byte with latency check.
    send_frame(8'hA5, BIT, 1'b1, 1'b1);
    hold(50);

    // Sender baud offsets of -3% / +3%, then random traffic.
    send_frame(8'h00, 62, 1'b1, 1'b0);
    send_frame(8'hFF, 66, 1'b1, 1'b0);
    send_frame(8'h55, 62, 1'b1, 1'b0);
    for (int n = 0; n < 12; n++) begin
      rd = 8'($urandom);
      send_frame(rd, int'($urandom_range(62, 66)), 1'b1, 1'b0);
      hold(int'($urandom_range(0, 40)));
    end
    hold(50);

    // Overrun: no ack, two back-to-back frames.
    auto_ack = 1'b0;
    fork
      begin
        send_frame(8'h3C, BIT, 1'b1, 1'b0);
        send_frame(8'h7E, BIT, 1'b1, 1'b0);
      end
      begin
        hold(630);
        chk("busy_between_frames", rx_busy, 0);
      end
    join
    hold(20);
    chk("overrun_data_kept", rx_data, 8'h3C);
    chk("overrun_valid_held", rx_valid, 1);
    man_ack = 1'b1;
    hold(3);
    man_ack = 1'b0;
    pending = 1'b0;
    chk("ack_clears_valid", rx_valid, 0);
    auto_ack = 1'b1;
    hold(50);

    // Framing error, then a long break that must not retrigger.
    send_frame(8'h81, BIT, 1'b0, 1'b0);
    hold(20 * BIT);
    chk("break_no_refire", rx_busy, 0);
    chk("ferr_valid_low", rx_valid, 0);
    rx_in = 1'b1;
    hold(3 * BIT);

    // Short glitch on an idle line.
    rx_in = 1'b0;
    hold(10);
    chk("glitch_busy", rx_busy, 1);
    hold(6);
    rx_in = 1'b1;
    hold(60);
    chk("glitch_idle", rx_busy, 0);
    chk("glitch_no_valid", rx_valid, 0);
    hold(2 * BIT);

    // Reset in the middle of data bit 4 of 0xC3.
    c3 = 8'hC3;
    rx_in = 1'b0;
    hold(BIT);
    for (int i = 0; i < 4; i++) begin
      rx_in = c3[i];
      hold(BIT);
    end
    rx_in = c3[4];
    hold(BIT / 2);
    chk("busy_in_data", rx_busy, 1);
    reset = 1'b1;
    #1;
    chk("midreset_data", rx_data, 0);
    chk("midreset_busy", rx_busy, 0);
    chk("midreset_valid", rx_valid, 0);
    hold(5);
    reset = 1'b0;
    hold(BIT / 2 + BIT);
    rx_in = 1'b1;
    hold(3 * BIT);
    send_frame(8'h12, BIT, 1'b1, 1'b0);
    hold(200);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
